// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// This block shares the single register-file write port between two
// writeback sources:
//   - src0 is the ALU result.
//   - src1 is the load data.
//
// Arbitration is round-robin with a valid/ready handshake on each source.
// The grant is combinational. The winning source is registered into the
// mux select, address and data, so a write reaches the register file one
// cycle after its transfer. A transfer to register 0 is accepted, but its
// write enable is suppressed. A saturating counter records every cycle in
// which both sources request while the pipeline is not stalled.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   stall                      while high, no grant is issued
//   src0_valid/addr/data       ALU writeback request
//   src0_ready                 combinational grant to src0
//   src1_valid/addr/data       load writeback request
//   src1_ready                 combinational grant to src1
//   mux_sel                    registered writeback mux select (0=src0, 1=src1)
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   conflict_cnt               saturating count of contended cycles
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              src0_valid,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  output logic              mux_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Source granted by the most recent transfer. It resets to 1 so that
  // src0 wins the first contention.
  logic last_grant;
  logic xfer0;
  logic xfer1;
  logic contend;

  // NOTE: both readies get a default before any branch, so that no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    if (!stall) begin
      // src0 wins when it is alone, or when src1 took the previous slot.
      // In every other case a valid src1 wins. At most one ready is high.
      if (src0_valid && (!src1_valid || last_grant)) begin
        src0_ready = 1'b1;
      end else if (src1_valid) begin
        src1_ready = 1'b1;
      end
    end
  end

  assign xfer0   = src0_valid && src0_ready;
  assign xfer1   = src1_valid && src1_ready;
  assign contend = src0_valid && src1_valid && !stall;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_sel    <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= 1'b1;
    end else begin
      // With no transfer, the write enable drops. Select, address, data
      // and last_grant keep their values.
      rf_we <= 1'b0;
      if (xfer0) begin
        mux_sel    <= 1'b0;
        rf_waddr   <= src0_addr;
        rf_wdata   <= src0_data;
        // A write to register 0 is acknowledged but never performed.
        rf_we      <= (src0_addr != '0);
        last_grant <= 1'b0;
      end else if (xfer1) begin
        mux_sel    <= 1'b1;
        rf_waddr   <= src1_addr;
        rf_wdata   <= src1_data;
        rf_we      <= (src1_addr != '0);
        last_grant <= 1'b1;
      end
    end
  end

  // The counter stops at all-ones and does not wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (contend && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// This bench runs directed vectors with hand-written grant expectations.
//
// The driver applies the inputs of each cycle at the falling edge. It then
// checks the combinational readies and pushes the expected registered
// outputs for the following rising edge into a queue. A separate monitor
// pops that queue shortly after each rising edge and compares the results.
//
// A second instance, built with CNT_W=4, shares the same inputs. It shows
// that the conflict counter saturates at 15.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              sel;
    logic [15:0]       cnt;
    logic [3:0]        cnt4;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              src0_valid;
  logic [ADDR_W-1:0] src0_addr;
  logic [DATA_W-1:0] src0_data;
  logic              src0_ready;
  logic              src1_valid;
  logic [ADDR_W-1:0] src1_addr;
  logic [DATA_W-1:0] src1_data;
  logic              src1_ready;
  logic              mux_sel;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [15:0]       conflict_cnt;

  logic              s_src0_ready;
  logic              s_src1_ready;
  logic              s_mux_sel;
  logic              s_rf_we;
  logic [ADDR_W-1:0] s_rf_waddr;
  logic [DATA_W-1:0] s_rf_wdata;
  logic [3:0]        s_conflict_cnt;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data),
    .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data),
    .src1_ready(src1_ready),
    .mux_sel(mux_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
  );

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data),
    .src0_ready(s_src0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data),
    .src1_ready(s_src1_ready),
    .mux_sel(s_mux_sel), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr),
    .rf_wdata(s_rf_wdata), .conflict_cnt(s_conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  exp_t mon_e;

  // Expected register state. It advances from the hand-given grants.
  logic              m_sel;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_cnt;
  int                m_cnt4;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp,
               $time);
    end
  endtask

  // Applies one cycle of stimulus and checks the readies against the
  // expected grants. It then queues the outputs expected after the next
  // rising edge.
  task automatic cycle(input logic st,
                       input logic v0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d1,
                       input logic g0, input logic g1);
    exp_t e;
    @(negedge clk);
    stall      = st;
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
    #1;
    check("src0_ready", {63'd0, src0_ready}, {63'd0, g0});
    check("src1_ready", {63'd0, src1_ready}, {63'd0, g1});
    e.we = 1'b0;
    if (g0) begin
      m_sel = 1'b0; m_addr = a0; m_data = d0; e.we = (a0 != 0);
    end else if (g1) begin
      m_sel = 1'b1; m_addr = a1; m_data = d1; e.we = (a1 != 0);
    end
    if (v0 && v1 && !st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    e.addr = m_addr;
    e.data = m_data;
    e.sel  = m_sel;
    e.cnt  = 16'(m_cnt);
    e.cnt4 = 4'(m_cnt4);
    q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    stall      = 1'b0;
    src0_valid = 1'b0; src0_addr = '0; src0_data = '0;
    src1_valid = 1'b0; src1_addr = '0; src1_data = '0;
    q.delete();
    m_sel = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_cnt4 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares the registered outputs just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!reset && q.size() > 0) begin
      mon_e = q.pop_front();
      check("rf_we",         {63'd0, rf_we},          {63'd0, mon_e.we});
      check("rf_waddr",      {59'd0, rf_waddr},       {59'd0, mon_e.addr});
      check("rf_wdata",      {32'd0, rf_wdata},       {32'd0, mon_e.data});
      check("mux_sel",       {63'd0, mux_sel},        {63'd0, mon_e.sel});
      check("conflict_cnt",  {48'd0, conflict_cnt},   {48'd0, mon_e.cnt});
      check("conflict_cnt4", {60'd0, s_conflict_cnt}, {60'd0, mon_e.cnt4});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state with both sources idle.
    #1;
    check("reset rf_we",    {63'd0, rf_we},        64'd0);
    check("reset rf_waddr", {59'd0, rf_waddr},     64'd0);
    check("reset rf_wdata", {32'd0, rf_wdata},     64'd0);
    check("reset mux_sel",  {63'd0, mux_sel},      64'd0);
    check("reset cnt",      {48'd0, conflict_cnt}, 64'd0);
    idle();

    // src0 alone.
    cycle(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, 1'b1, 1'b0);
    idle();

    // Four cycles of contention from reset: src0, src1, src0, src1.
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB,
            (i % 2) == 0, (i % 2) == 1);
    idle();
    check("cnt after contention", {48'd0, conflict_cnt}, 64'd4);

    // Load to $zero: accepted, but the write is suppressed.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    idle();

    // Stall with both valid: no grants, and the count holds.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
    // After release, last_grant=src1 from the $zero load, so src0 goes first.
    cycle(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    idle();

    // Reset asserted mid-transfer clears the outputs without a clock edge.
    cycle(1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async rf_we",    {63'd0, rf_we},    64'd0);
    check("async rf_wdata", {32'd0, rf_wdata}, 64'd0);
    check("async rf_waddr", {59'd0, rf_waddr}, 64'd0);
    do_reset();

    // Saturation: 20 contended cycles. The 4-bit counter stops at 15.
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h1010,
            (i % 2) == 0, (i % 2) == 1);
    idle();
    check("cnt4 saturated", {60'd0, s_conflict_cnt}, 64'd15);
    check("cnt16 count",    {48'd0, conflict_cnt},   64'd20);

    idle();
    idle();
    @(posedge clk);
    #2;
    check("queue drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: src0 (ALU result) and src1 (load data).
- Arbitrates round-robin with a valid/ready handshake per source.
- Drives the select of the 32-bit 2:1 writeback mux and registers the winning address and data for one-cycle-latency delivery to the register file.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, width of register address.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall; while high no grant is issued.
- src0_valid  input  1  ALU writeback request.
- src0_addr  input  ADDR_W  ALU destination register.
- src0_data  input  DATA_W  ALU result.
- src0_ready  output  1  grant to src0, combinational.
- src1_valid  input  1  load writeback request.
- src1_addr  input  ADDR_W  load destination register.
- src1_data  input  DATA_W  load data.
- src1_ready  output  1  grant to src1, combinational.
- mux_sel  output  1  registered writeback mux select (0 = src0, 1 = src1).
- rf_we  output  1  registered register-file write enable.
- rf_waddr  output  ADDR_W  registered write address.
- rf_wdata  output  DATA_W  registered write data.
- conflict_cnt  output  CNT_W  count of contended cycles, saturating.

Behaviour:
- Reset, asynchronous and active-high:
  - mux_sel=0, rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0.
  - Internal last_grant=1, so src0 wins the first contention.
- Grant logic, combinational, evaluated each cycle:
  - stall=1: src0_ready=src1_ready=0.
  - Exactly one valid: that source is granted.
  - Both valid: the source that is not last_grant is granted.
  - Neither valid: no grant.
  - At most one ready is high in any cycle.
- Transfer occurs when srcN_valid && srcN_ready. On the next rising edge:
  - mux_sel <= N.
  - rf_waddr <= srcN_addr.
  - rf_wdata <= srcN_data.
  - rf_we <= (srcN_addr != 0). A write to $zero is accepted (ready high) but suppressed.
  - last_grant <= N.
- No transfer in a cycle: rf_we <= 0 next edge. mux_sel, rf_waddr, rf_wdata and last_grant hold.
- Latency is one cycle from transfer to rf_we. Throughput is one write per cycle.
- Requesters hold valid, addr and data stable until ready. Nothing is queued internally, so a stalled or losing request is never dropped.
- Sustained contention alternates strictly: src0, src1, src0, and so on.
- conflict_cnt increments by 1 on each cycle with src0_valid && src1_valid && !stall. It holds at 2^CNT_W-1 once reached.
- stall does not affect the output registers except via "no transfer": rf_we drops one cycle after stall rises.
- Reset asserted mid-operation clears everything immediately, independent of clk. A write registered in that cycle is lost. Requesters re-present because they were not yet acknowledged, or were acknowledged but must re-issue, per the pipeline flush.
- Deassertion of reset is synchronous to clk at the integration level. The block assumes no grant during the reset-release cycle.

Test Plan:
1. Reset, then idle: all outputs 0. Assert reset mid-transfer -> rf_we and rf_wdata go to 0 without waiting for a clock edge.
2. src0 alone, addr=5, data=0x12345678 -> src0_ready=1 the same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, mux_sel=0.
3. Both valid for 4 cycles from reset (src0 addr=1 data=0xA, src1 addr=2 data=0xB):
   - Grants go src0, src1, src0, src1.
   - mux_sel sequence 0,1,0,1, each one cycle later.
   - conflict_cnt=4.
4. src1 valid with addr=0, data=0xDEADBEEF -> src1_ready=1. Next cycle rf_we=0 and rf_wdata=0xDEADBEEF.
5. stall=1 for 3 cycles with both valid:
   - No ready in those cycles; rf_we=0; conflict_cnt unchanged.
   - After release, the grant follows last_grant order.
6. Force conflict_cnt near saturation (CNT_W=4 build), then contend 20 cycles -> counter stops at 15, with no wrap.
